// File: rtl/btn_conditioner_if.sv
// rtl/btn_conditioner_if.sv - button conditioner signal bundle: raw buttons in, clean level and strobes out
interface btn_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    modport master (
        output btn,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - per-channel synchronizer, debouncer, press/release strobes and optional auto-repeat
module btn_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic            clk,
    input  logic            rst,
    btn_conditioner_if.slave bus
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX) + 1;

    localparam logic [DW-1:0] D_LIMIT   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LIMIT  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LIMIT  = RW'(REPEAT_PERIOD - 1);

    logic [N_BTN-1:0] s1;
    logic [N_BTN-1:0] s2;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] rel;

    // Two-flop synchronizer bringing the asynchronous buttons into the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.btn;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [DW-1:0] cnt;
        logic          lvl;
        logic          prs;
        logic          rls;
        logic          at_limit;
        logic          acc_press;
        logic          acc_rel;

        // A new level is accepted only after it has differed for the full count
        assign at_limit  = (s2[i] != lvl) && (cnt == D_LIMIT);
        assign acc_press = at_limit & s2[i];
        assign acc_rel   = at_limit & ~s2[i];

        // Debounce counter, accepted level and registered release strobe
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt <= '0;
                lvl <= 1'b0;
                rls <= 1'b0;
            end else begin
                rls <= acc_rel;
                if (s2[i] == lvl) begin
                    cnt <= '0;
                end else if (cnt == D_LIMIT) begin
                    lvl <= s2[i];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + DW'(1);
                end
            end
        end

        if (REPEAT_EN != 0) begin : g_rep
            typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RUN} rstate_t;
            rstate_t       rstate;
            logic [RW-1:0] rcnt;

            // Repeat FSM: initial delay then periodic presses; an accepted release always wins
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rstate <= R_IDLE;
                    rcnt   <= '0;
                    prs    <= 1'b0;
                end else begin
                    prs <= acc_press;
                    if (acc_rel) begin
                        rstate <= R_IDLE;
                        rcnt   <= '0;
                    end else if (acc_press) begin
                        rstate <= R_DELAY;
                        rcnt   <= '0;
                    end else begin
                        case (rstate)
                            R_DELAY: begin
                                if (rcnt == RD_LIMIT) begin
                                    prs    <= 1'b1;
                                    rcnt   <= '0;
                                    rstate <= R_RUN;
                                end else begin
                                    rcnt <= rcnt + RW'(1);
                                end
                            end
                            R_RUN: begin
                                if (rcnt == RP_LIMIT) begin
                                    prs  <= 1'b1;
                                    rcnt <= '0;
                                end else begin
                                    rcnt <= rcnt + RW'(1);
                                end
                            end
                            default: begin
                                rcnt <= '0;
                            end
                        endcase
                    end
                end
            end
        end else begin : g_norep
            // Single press strobe per accepted press
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    prs <= 1'b0;
                end else begin
                    prs <= acc_press;
                end
            end
        end

        assign level[i] = lvl;
        assign press[i] = prs;
        assign rel[i]   = rls;
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = rel;
endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream input-conditioning stage for the board push-buttons.
- Synchronizes each raw button into the clk domain, debounces it, and produces a clean level plus single-cycle press and release strobes.
- Optionally generates auto-repeat press strobes while a button is held.
- Downstream FSM stages use btn_press as a clock enable on clk; buttons are never used as clocks.

Parameters:
- N_BTN, 5, number of button channels.
- DEBOUNCE_CYCLES, 20'd500000, consecutive stable cycles required to accept a new level; legal range ≥2.
- REPEAT_EN, 0, 1 enables auto-repeat press strobes.
- REPEAT_DELAY, 25000000, cycles from the accepted press to the first repeat strobe; legal range ≥2.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat strobes; legal range ≥2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn  input  N_BTN  raw buttons; 1 = pressed; asynchronous to clk.
- btn_level  output  N_BTN  debounced level per channel.
- btn_press  output  N_BTN  one-cycle strobe on an accepted press, and on each auto-repeat.
- btn_release  output  N_BTN  one-cycle strobe on an accepted release.

Behaviour:
- Reset (rst=0, asynchronous): sync flops, btn_level, btn_press, btn_release and all counters are cleared to 0. Outputs stay 0 for as long as rst is low.
- Synchronizer: per channel, two flops s1←btn, s2←s1. Only s2 feeds the debouncer.
- Debounce counter: one counter per channel, width $clog2(DEBOUNCE_CYCLES)+1.
  - If s2==btn_level: cnt←0.
  - Else if cnt==DEBOUNCE_CYCLES-1: btn_level←s2, cnt←0, and the matching strobe (press if s2=1, release if s2=0) is asserted for exactly this one cycle.
  - Else: cnt←cnt+1.
- Latency: a raw change captured into s1 at edge 0, held stable, updates btn_level and the strobe at edge DEBOUNCE_CYCLES+1.
- Glitch rejection: if s2 returns to btn_level before the count completes, cnt clears, with no level change and no strobe. An s2 excursion shorter than DEBOUNCE_CYCLES cycles is always rejected.
- Strobes: registered outputs, high for exactly one cycle, 0 in all other cycles. btn_press and btn_release are never high together on the same channel.
- Auto-repeat (REPEAT_EN=1), one repeat counter per channel, width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD))+1:
  - States: R_IDLE, R_DELAY, R_RUN.
  - Accepted press: enter R_DELAY with rcnt←0.
  - R_DELAY: when rcnt==REPEAT_DELAY-1, pulse btn_press, rcnt←0, go to R_RUN.
  - R_RUN: when rcnt==REPEAT_PERIOD-1, pulse btn_press, rcnt←0.
  - Accepted release (btn_level 1→0) from any state: go to R_IDLE, rcnt←0. No repeat strobe is issued on the release edge; release takes priority.
  - Repeat strobes are timed relative to the accepted press edge P: first at P+REPEAT_DELAY, then P+REPEAT_DELAY+k·REPEAT_PERIOD.
- REPEAT_EN=0: repeat logic is absent and btn_press fires once per accepted press.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous strobes.
- Reset mid-operation: all state is lost. A button still held after rst deasserts is accepted as a fresh press DEBOUNCE_CYCLES+1 edges after the first post-reset sampling edge.
- Power-on: a button held through reset produces exactly one btn_press after reset release.

Test Plan:
- DEBOUNCE_CYCLES=4, REPEAT_EN=0: btn[0] 0→1 captured at edge 0 and held → btn_level[0]=1 and btn_press=5'b00001 at edge 5 only. btn_release stays 0.
- Glitch: btn[2] high for 3 cycles, then low → btn_level, btn_press and btn_release all remain 0. A 4-cycle pulse (at s2) → press strobe, followed by a release strobe.
- Bounce: btn[1] toggles 1,0,1,0,1 one cycle each, then holds 1 → exactly one btn_press[1] pulse, 5 edges after the final stable capture.
- Auto-repeat, DEBOUNCE_CYCLES=4, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=3, btn[4] held for 30 cycles after acceptance at P → btn_press[4] at P, P+10, P+13, …, P+28. Release then gives one btn_release[4] and no further presses.
- Simultaneous: btn=5'b10001 asserted on the same edge → btn_press=5'b10001 in a single cycle. Releasing btn[0] alone → btn_release=5'b00001, while btn_level[4] stays 1.
- Reset mid-count: assert rst=0 with cnt=2 and btn[3] held → outputs are 0 immediately. Release rst with btn[3] still held → btn_press[3] fires exactly once, 5 edges after the first sampling edge.
